// File: rtl/box_fill_writer.sv
// Purpose: rectangle fill engine; emits one video-memory pixel write per clock in raster order (x fastest, then y).
// Latency: first pixel on x/y/plot one cycle after start is accepted; done pulses one cycle after the last pixel.
// Backpressure: none; start is honoured only in IDLE and not while done is high, otherwise dropped (not queued).
//
// Ports:
//   clock, resetn           rising-edge clock, asynchronous active-low reset
//   start                   command strobe (x0, y0, w, h, colour latched on acceptance)
//   x0, y0, w, h, colour    rectangle origin, size in dots (0 = empty command) and fill colour
//   busy, done              command in progress / one-cycle completion pulse
//   x, y, colour_out, plot  video memory write port (all registered)
module box_fill_writer #(
  parameter string RESOLUTION              = "320x240",
  parameter int    BITS_PER_COLOUR_CHANNEL = 1,
  parameter string MONOCHROME              = "FALSE",
  localparam int   XW = (RESOLUTION == "160x120") ? 8 : 9,
  localparam int   YW = (RESOLUTION == "160x120") ? 7 : 8,
  localparam int   CW = (MONOCHROME == "TRUE") ? 1 : 3 * BITS_PER_COLOUR_CHANNEL
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  input  logic [CW-1:0] colour,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour_out,
  output logic          plot
);

  localparam int XMAX = (RESOLUTION == "160x120") ? 160 : 320;
  localparam int YMAX = (RESOLUTION == "160x120") ? 120 : 240;
  localparam logic [XW:0] X_LIM = (XW+1)'(XMAX);
  localparam logic [YW:0] Y_LIM = (YW+1)'(YMAX);

  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

  state_t        state;
  logic [XW-1:0] x0_r;
  logic [YW-1:0] y0_r;
  logic [XW-1:0] wm1_r;   // last column index of the command
  logic [YW-1:0] hm1_r;   // last row index of the command
  logic [CW-1:0] col_r;
  logic [XW-1:0] i;
  logic [YW-1:0] j;

  // One extra bit so a rectangle running off the right/bottom edge is
  // seen as clipped rather than wrapping back onto the screen.
  logic [XW:0] px;
  logic [YW:0] py;

  assign px = {1'b0, x0_r} + {1'b0, i};
  assign py = {1'b0, y0_r} + {1'b0, j};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      x0_r       <= '0;
      y0_r       <= '0;
      wm1_r      <= '0;
      hm1_r      <= '0;
      col_r      <= '0;
      i          <= '0;
      j          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          plot <= 1'b0;
          // The cycle in which done is high is already IDLE; a start seen
          // then is dropped so a held start cannot re-trigger immediately.
          if (start && !done) begin
            x0_r  <= x0;
            y0_r  <= y0;
            col_r <= colour;
            // Only used when both sizes are non-zero, so no underflow matters.
            wm1_r <= w - XW'(1);
            hm1_r <= h - YW'(1);
            i     <= '0;
            j     <= '0;
            busy  <= 1'b1;
            state <= (w == '0 || h == '0) ? FINISH : DRAW;
          end
        end
        DRAW: begin
          x          <= px[XW-1:0];
          y          <= py[YW-1:0];
          colour_out <= col_r;
          plot       <= (px < X_LIM) && (py < Y_LIM);
          if (i == wm1_r) begin
            i <= '0;
            j <= j + YW'(1);
            if (j == hm1_r) begin
              state <= FINISH;
            end
          end else begin
            i <= i + XW'(1);
          end
        end
        FINISH: begin
          plot  <= 1'b0;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_box_fill_writer.sv
// Purpose: self-checking bench for box_fill_writer (320x240, 3-bit colour) against a loop-based raster model.
// Latency: checks pixel k at edge N+1+k after acceptance at edge N and done at edge N+1+w*h.
// Backpressure: exercises start during a command and during the done cycle (both must be dropped).
module tb_box_fill_writer;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [8:0] x0 = '0;
  logic [7:0] y0 = '0;
  logic [8:0] w = '0;
  logic [7:0] h = '0;
  logic [2:0] colour = '0;
  logic       busy;
  logic       done;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour_out;
  logic       plot;

  int vectors = 0;
  int errors  = 0;

  // Model of what x/y/colour_out currently hold (they keep the last drawn pixel).
  int prev_x = 0;
  int prev_y = 0;
  int prev_col = 0;

  box_fill_writer #(
    .RESOLUTION("320x240"),
    .BITS_PER_COLOUR_CHANNEL(1),
    .MONOCHROME("FALSE")
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .start(start),
    .x0(x0),
    .y0(y0),
    .w(w),
    .h(h),
    .colour(colour),
    .busy(busy),
    .done(done),
    .x(x),
    .y(y),
    .colour_out(colour_out),
    .plot(plot)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and check every cycle until done has come and gone.
  // glitch_k: pixel index during which a stray start with altered inputs is raised (-1 = none).
  // abort_k : pixel index during which reset is asserted and the task returns (-1 = none).
  // start_in_done: raise start during the done cycle; it must be ignored.
  task automatic run_cmd(input int cx0, input int cy0, input int cw, input int ch, input int ccol,
                         input int glitch_k, input int abort_k, input bit start_in_done);
    int n;
    int px;
    int py;
    int exp_plots;
    int obs_plots;
    logic pl;
    n = cw * ch;
    exp_plots = 0;
    obs_plots = 0;
    x0 = 9'(cx0);
    y0 = 8'(cy0);
    w = 9'(cw);
    h = 8'(ch);
    colour = 3'(ccol);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("accept_busy_done_plot", {29'b0, busy, done, plot}, 32'b100);
    for (int k = 0; k < n; k++) begin
      start = (k == glitch_k);
      if (k == glitch_k) begin
        x0 = x0 ^ 9'h0AA;
        y0 = y0 + 8'd9;
        w = w + 9'd3;
        colour = ~colour;
      end
      @(posedge clock);
      #1;
      if (k == abort_k) begin
        #1;
        resetn = 1'b0;
        #1;
        chk("reset_outputs_zero", {11'b0, busy, done, plot, x, y, colour_out}, 32'b0);
        start = 1'b0;
        prev_x = 0;
        prev_y = 0;
        prev_col = 0;
        return;
      end
      px = cx0 + (k % cw);
      py = cy0 + (k / cw);
      pl = (px < 320) && (py < 240);
      if (pl) exp_plots++;
      if (plot) obs_plots++;
      prev_x = px % 512;
      prev_y = py % 256;
      prev_col = ccol;
      chk("pixel", {11'b0, plot, x, y, colour_out},
          {11'b0, pl, 9'(prev_x), 8'(prev_y), 3'(prev_col)});
      chk("draw_busy_done", {30'b0, busy, done}, 32'b10);
    end
    start = 1'b0;
    @(posedge clock);
    #1;
    chk("done_pulse", {30'b0, busy, done}, 32'b01);
    chk("finish_hold", {11'b0, plot, x, y, colour_out},
        {12'b0, 9'(prev_x), 8'(prev_y), 3'(prev_col)});
    chk("plot_count", 32'(obs_plots), 32'(exp_plots));
    start = start_in_done;
    @(posedge clock);
    #1;
    chk("post_done_idle", {29'b0, busy, done, plot}, 32'b0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset_state", {11'b0, busy, done, plot, x, y, colour_out}, 32'b0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    chk("idle_after_reset", {29'b0, busy, done, plot}, 32'b0);

    // Basic 2x2 fill
    run_cmd(10, 5, 2, 2, 3'b101, -1, -1, 1'b0);

    // Empty commands: w=0 and h=0
    run_cmd(20, 20, 0, 7, 3'b011, -1, -1, 1'b0);
    run_cmd(20, 20, 5, 0, 3'b011, -1, -1, 1'b0);

    // Clipping at the bottom-right corner
    run_cmd(318, 239, 4, 2, 3'b110, -1, -1, 1'b0);

    // Stray start mid-command, then start held through the done cycle
    run_cmd(40, 30, 3, 3, 3'b010, 2, -1, 1'b1);
    run_cmd(7, 8, 2, 1, 3'b111, -1, -1, 1'b0);

    // Reset during pixel 3 of a 4x4 command
    run_cmd(50, 60, 4, 4, 3'b001, -1, 3, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      chk("held_reset_quiet", {29'b0, busy, done, plot}, 32'b0);
    end
    @(negedge clock);
    resetn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock);
      #1;
      chk("no_done_after_abort", {29'b0, busy, done, plot}, 32'b0);
    end
    run_cmd(0, 0, 1, 1, 3'b100, -1, -1, 1'b0);

    // Randomized commands, some straddling the clip edges, some empty
    for (int r = 0; r < 16; r++) begin
      int rx;
      int ry;
      int rw;
      int rh;
      int gk;
      rx = ($urandom_range(0, 1) != 0) ? $urandom_range(300, 340) : $urandom_range(0, 511);
      ry = ($urandom_range(0, 1) != 0) ? $urandom_range(230, 250) : $urandom_range(0, 255);
      rw = $urandom_range(0, 6);
      rh = $urandom_range(0, 5);
      gk = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : -1;
      run_cmd(rx, ry, rw, rh, $urandom_range(0, 7), gk, -1, $urandom_range(0, 1) != 0);
    end

    // Full screen
    run_cmd(0, 0, 320, 240, 3'b011, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/box_fill_writer.md
Name: box_fill_writer

Overview:
- Drawing engine on the write side of video memory; the VGA scan-out controller reads the same memory on the other port.
- Accepts a rectangle command (origin, size, colour) and emits one pixel write per clock in raster order: x fastest, then y.
- Outputs drive the video memory write port directly (x, y, colour, plot). The memory's address translator maps (x,y) to an address.

Parameters:
- RESOLUTION, "320x240", "320x240" or "160x120"; sets coordinate widths and clip limits.
  - XW = 9, YW = 8, XMAX = 320, YMAX = 240 for "320x240".
  - XW = 8, YW = 7, XMAX = 160, YMAX = 120 for "160x120".
- BITS_PER_COLOUR_CHANNEL, 1, colour bits per R/G/B channel.
- MONOCHROME, "FALSE", "TRUE" gives a 1-bit colour.
- CW (derived), colour width: 1 if MONOCHROME = "TRUE", else 3*BITS_PER_COLOUR_CHANNEL.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- x0  in  XW  rectangle left column.
- y0  in  YW  rectangle top row.
- w  in  XW  rectangle width in dots; 0 means an empty command.
- h  in  YW  rectangle height in dots; 0 means an empty command.
- colour  in  CW  fill colour.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at command completion.
- x  out  XW  write column.
- y  out  YW  write row.
- colour_out  out  CW  write colour.
- plot  out  1  write enable to video memory.

Behaviour:
- All outputs are registered. Reset value of every output is 0: busy, done, plot, x, y, colour_out. FSM resets to IDLE.
- FSM states: IDLE, DRAW, FINISH.
- IDLE:
  - On start=1 at edge N, latch x0, y0, w, h, colour into internal registers.
  - Clear column counter i (XW bits) and row counter j (YW bits).
  - If w=0 or h=0, go to FINISH. Otherwise go to DRAW.
  - busy=1 from edge N onward.
- DRAW, one pixel per cycle:
  - Compute px = x0+i and py = y0+j in XW+1 / YW+1 bits, so there is no wrap.
  - Register x = px[XW-1:0] and y = py[YW-1:0].
  - colour_out = latched colour.
  - plot = (px < XMAX) && (py < YMAX). Clipped pixels consume their cycle with plot=0.
  - Counter update: if i = w-1, then i ← 0 and j ← j+1; otherwise i ← i+1.
  - When i = w-1 and j = h-1, go to FINISH.
- Latency: the first pixel's plot/x/y are valid in the cycle after edge N (from edge N+1). Pixel k (0-based) is valid from edge N+1+k.
- FINISH:
  - plot ← 0; done ← 1 for exactly one cycle; busy ← 0 at the same edge.
  - Return to IDLE.
  - Timing: for a w×h command, done is high from edge N+1+w·h. An empty command asserts done from edge N+1 with no plot.
- start while busy (DRAW or FINISH) is ignored and not queued. start in the same cycle done is high is also ignored. A new command is accepted only in IDLE, the cycle after done.
- Input changes on x0/y0/w/h/colour after acceptance have no effect on the command in progress.
- plot=0 in IDLE and FINISH. x/y/colour_out hold their last values when plot=0.
- Reset asserted mid-command: immediate return to IDLE, all outputs 0, no done pulse, command discarded.
- Maximum command (w = h = all-ones) must iterate fully without counter overflow. Counter compare is against w-1 and h-1 computed after the zero check.

Test Plan:
- 320x240, start with x0=10, y0=5, w=2, h=2, colour=3'b101 -> plot=1 on 4 consecutive cycles: (10,5), (11,5), (10,6), (11,6), colour_out=101. done pulses on the next cycle; busy high for 5 cycles.
- w=0, h=7, start -> busy for 1 cycle, done pulse, plot never asserted.
- Clipping: x0=318, y0=239, w=4, h=2 -> 8 DRAW cycles. plot=1 only for (318,239) and (319,239); the other 6 cycles have plot=0. done after cycle 8.
- start pulsed again mid-command with different x0/colour -> the output sequence is identical to the original command and no second command runs. A start one cycle after done is accepted.
- Reset: assert resetn=0 during pixel 3 of a 4×4 command -> all outputs 0 asynchronously. After release, IDLE; no done; a fresh 1×1 command at (0,0) works.
- Full screen: x0=0, y0=0, w=320, h=240 -> exactly 76800 plots, first (0,0), last (319,239), done at cycle 76801. 160x120 build: w=160, h=120 gives 19200 plots.
